qkv_load_dma: RTL and testbench
===============================

Name: qkv_load_dma

Overview:
- Load DMA engine directly downstream of top_controller's DMA enables.
- One instance serves each of enable_weight_dma, enable_loadk_dma, enable_loadq_dma and enable_loadscore_dma.
- On enable it moves a burst of `len` words from the external read port into a local CIM/score buffer write port. It returns a one-cycle done pulse that feeds the matching done_*_dma input of top_controller.
- An internal credit-limited skid FIFO absorbs read latency and write backpressure.

Parameters:
- DATA_W, 64, width of one transfer word.
- ADDR_W, 16, source and destination word-address width.
- LEN_W, 8, burst length width (max 2^LEN_W-1 words).
- FIFO_DEPTH, 4, skid FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  start request from top_controller (level; held high by controller).
- src_base  in  ADDR_W  first source word address, sampled at start.
- dst_base  in  ADDR_W  first destination word address, sampled at start.
- len  in  LEN_W  words to transfer, sampled at start.
- done  out  1  one-cycle pulse at end of burst.
- busy  out  1  high from start until done pulse inclusive.
- err  out  1  sticky protocol error.
- rd_req  out  1  read request.
- rd_addr  out  ADDR_W  read address.
- rd_gnt  in  1  request accepted when rd_req&rd_gnt.
- rd_valid  in  1  read data return (in order, latency ≥1, any).
- rd_data  in  DATA_W  read data.
- wr_en  out  1  buffer write.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  DATA_W  buffer write data.
- wr_ready  in  1  write accepted when wr_en&wr_ready.

Behaviour:
- Reset values (async, rst=0): state=IDLE; all counters 0; FIFO empty; done=busy=err=rd_req=wr_en=0; rd_addr=wr_addr=wr_data=0.
- IDLE: if enable=1, latch src_base, dst_base and len into internal registers. Clear err. Go to RUN, or to DONE if len=0.
- RUN:
  - rd_req=1 while issued<len_q and (outstanding+fifo_count)<FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
  - rd_addr = src_q + issued, mod 2^ADDR_W (wraps silently).
  - rd_req goes high the cycle after the start is detected. rd_addr is held stable while rd_req=1 and rd_gnt=0.
  - outstanding increments on grant and decrements on rd_valid; simultaneous events net to zero.
  - rd_valid pushes rd_data into the FIFO.
  - wr_en = FIFO not empty; wr_data = FIFO head; wr_addr = dst_q + written, mod 2^ADDR_W.
  - Pop and increment written on wr_en&wr_ready. Push and pop in the same cycle are legal, including with a full FIFO and a pop.
  - When written reaches len_q (the cycle the last write is accepted), go to DONE.
- DONE: done=1 for exactly one cycle, busy still 1. Then go to WAIT_LOW.
- WAIT_LOW: busy=0. Stay until enable=0, then go to IDLE. A held-high enable never retriggers; a new burst needs an enable low→high.
- Best-case throughput is 1 word/cycle with zero-latency-style grants and wr_ready=1.
- Best-case latency from enable to done is len+3 cycles with read latency 1.
- Deasserting enable mid-burst has no effect; the burst completes.
- rd_valid with outstanding=0 (any state): set err (sticky until next start); data dropped, FIFO and counters unchanged.
- Reset mid-burst: immediate return to reset values. Any read data still returning afterwards sets err. This is expected, and the bench tolerates it.
- Counter widths: issued and written are LEN_W bits. outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package dma_pkg: state enum (IDLE, RUN, DONE, WAIT_LOW) and default width constants (DATA_W, ADDR_W, LEN_W).
- Sub-module dma_skid_fifo: synchronous FIFO, parameters DATA_W/DEPTH, ports push/pop/full/empty/count. The controller FSM and address counters stay in qkv_load_dma.

Test Plan:
- len=4, src=0x0010, dst=0x0200, rd_gnt=1, read latency 1, wr_ready=1: writes land at 0x0200..0x0203 with data from 0x0010..0x0013, in order. done pulses once at cycle 7 after enable; busy falls the next cycle.
- len=0: done pulses 1 cycle after enable; no rd_req or wr_en ever asserted.
- len=16, wr_ready low for 10 cycles mid-burst, latency 3: rd_req stalls once outstanding+fifo_count=4; no data lost or duplicated; 16 ordered writes; one done.
- src=0xFFFE, dst=0xFFFF, len=3: rd_addr sequence FFFE, FFFF, 0000; wr_addr sequence FFFF, 0000, 0001.
- enable held high 50 cycles after done: exactly one done. Drop enable then re-raise it with len=2: second burst runs and emits a second done.
- Spurious rd_valid in IDLE: err=1 and no write. Next start clears err. rst=0 mid-burst at word 5 of 8: all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and default widths for the load DMA
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        WAIT_LOW
    } dma_state_e;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 8;

endpackage

// File: rtl/qkv_load_dma_if.sv
// rtl/qkv_load_dma_if.sv - read port and buffer write port bundle for the load DMA
interface qkv_load_dma_if #(
    parameter int DATA_W = dma_pkg::DATA_W,
    parameter int ADDR_W = dma_pkg::ADDR_W
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output rd_req, rd_addr,
        input  rd_gnt, rd_valid, rd_data,
        output wr_en, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_gnt, rd_valid, rd_data,
        input  wr_en, wr_addr, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/dma_skid_fifo.sv
// rtl/dma_skid_fifo.sv - small synchronous FIFO between read returns and buffer writes
module dma_skid_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    // Storage needs no reset; count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/qkv_load_dma.sv
// rtl/qkv_load_dma.sv - burst copy from external read port into a local buffer, one done pulse per enable
module qkv_load_dma #(
    parameter int DATA_W     = dma_pkg::DATA_W,
    parameter int ADDR_W     = dma_pkg::ADDR_W,
    parameter int LEN_W      = dma_pkg::LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    output logic              done,
    output logic              busy,
    output logic              err,
    qkv_load_dma_if.master    bus
);
    import dma_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

    dma_state_e        state;
    dma_state_e        state_nxt;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  written;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              start;
    logic              rd_fire;
    logic              wr_fire;
    logic              rd_ok;
    logic              rd_spurious;
    logic              rd_req_int;
    logic              wr_en_int;

    assign start       = (state == IDLE) && enable;
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign rd_ok       = bus.rd_valid && (outstanding != '0);
    assign rd_spurious = bus.rd_valid && (outstanding == '0);

    // Every granted read owns a FIFO slot until written, so the FIFO cannot overflow.
    assign rd_req_int  = (state == RUN) && (issued < len_q) && (credit_used < CREDIT_MAX);
    assign wr_en_int   = (state == RUN) && !fifo_empty;
    assign rd_fire     = rd_req_int && bus.rd_gnt;
    assign wr_fire     = wr_en_int && bus.wr_ready;
    assign fifo_push   = rd_ok && (!fifo_full || wr_fire);

    assign bus.rd_req  = rd_req_int;
    assign bus.rd_addr = rd_req_int ? (src_q + ADDR_W'(issued)) : '0;
    assign bus.wr_en   = wr_en_int;
    assign bus.wr_addr = wr_en_int ? (dst_q + ADDR_W'(written)) : '0;
    assign bus.wr_data = wr_en_int ? fifo_head : '0;

    assign done = (state == DONE);
    assign busy = (state == RUN) || (state == DONE);

    dma_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (bus.rd_data),
        .pop   (wr_fire),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (wr_fire && ((written + LEN_W'(1)) == len_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE:     state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            issued      <= '0;
            written     <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                src_q   <= src_base;
                dst_q   <= dst_base;
                len_q   <= len;
                issued  <= '0;
                written <= '0;
            end else begin
                if (rd_fire) begin
                    issued <= issued + LEN_W'(1);
                end
                if (wr_fire) begin
                    written <= written + LEN_W'(1);
                end
            end
            case ({rd_fire, rd_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: ;
            endcase
            // An unexpected return in the start cycle still counts as an error.
            if (rd_spurious) begin
                err <= 1'b1;
            end else if (start) begin
                err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_qkv_load_dma.sv
// tb/tb_qkv_load_dma.sv - scoreboard bench for qkv_load_dma
module tb_qkv_load_dma;
    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 16;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
    } rd_pend_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              done;
    logic              busy;
    logic              err;

    qkv_load_dma_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    qkv_load_dma #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .src_base (src_base),
        .dst_base (dst_base),
        .len      (len),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    rd_pend_t          pend[$];
    wr_exp_t           sb[$];
    logic [ADDR_W-1:0] rd_log[$];

    logic gnt_en    = 1'b1;
    logic wr_rdy_en = 1'b1;
    logic inject    = 1'b0;
    int   lat       = 1;
    int   granted   = 0;
    int   written_cnt  = 0;
    int   rdreq_cycles = 0;
    int   wren_cycles  = 0;
    int   done_seen    = 0;
    int   max_inflight = 0;
    int   en_cyc       = 0;

    function automatic logic [DATA_W-1:0] rdata(input logic [ADDR_W-1:0] a);
        return {a ^ 16'h5a5a, 16'hc0de, a, ~a};
    endfunction

    // Memory responder and write monitor, run on the falling edge.
    always @(negedge clk) begin
        int      inflight;
        wr_exp_t e;
        inflight = granted - written_cnt;
        if (inflight > max_inflight) max_inflight = inflight;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        if (!rst) pend.delete();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = rdata(pend[0].addr);
            void'(pend.pop_front());
        end else if (inject) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = '1;
            inject = 1'b0;
        end
        bus.rd_gnt   = gnt_en;
        bus.wr_ready = wr_rdy_en;
        if (rst) begin
            if (done) done_seen++;
            if (bus.rd_req) rdreq_cycles++;
            if (bus.wr_en) wren_cycles++;
            if (bus.rd_req && bus.rd_gnt) begin
                pend.push_back('{due: cyc + lat, addr: bus.rd_addr});
                rd_log.push_back(bus.rd_addr);
                granted++;
            end
            if (bus.wr_en && bus.wr_ready) begin
                chk_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL wr_unexpected: got addr %h data %h, required no write", bus.wr_addr, bus.wr_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.wr_addr !== e.addr || bus.wr_data !== e.data)
                        $display("FAIL wr_order: got addr %h data %h, required addr %h data %h",
                                 bus.wr_addr, bus.wr_data, e.addr, e.data);
                    else
                        pass_cnt++;
                end
                written_cnt++;
            end
        end
    end

    task automatic start_burst(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                               input logic [LEN_W-1:0] n);
        @(posedge clk); #2;
        for (int k = 0; k < int'(n); k++)
            sb.push_back('{addr: d + 16'(k), data: rdata(s + 16'(k))});
        src_base = s;
        dst_base = d;
        len      = n;
        enable   = 1'b1;
        en_cyc   = cyc;
    endtask

    task automatic wait_done(input string name, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        chk_cnt++;
        if (dcyc < 0) $display("FAIL %s_done_timeout: no done, required within %0d cycles", name, budget);
        else pass_cnt++;
    endtask

    task automatic end_burst;
        @(posedge clk); #2;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic clear_counts;
        granted = 0; written_cnt = 0; max_inflight = 0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_cnt++;
        if ({done, busy, err, bus.rd_req, bus.wr_en} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, required 00000", {done, busy, err, bus.rd_req, bus.wr_en});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.rd_addr, bus.wr_addr, bus.wr_data} !== '0)
            $display("FAIL reset_data: got %h %h %h, required 0", bus.rd_addr, bus.wr_addr, bus.wr_data);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int dc;
        int d0;
        clear_counts();
        lat = 1; gnt_en = 1'b1; wr_rdy_en = 1'b1;
        d0 = done_seen;
        start_burst(16'h0010, 16'h0200, 8'd4);
        wait_done("basic", 50, dc);
        chk_cnt++;
        if (dc - en_cyc !== 7) $display("FAIL basic_latency: got %0d, required 7", dc - en_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL basic_busy_at_done: got %b, required 1", busy);
        else pass_cnt++;
        @(posedge clk); #2;
        chk_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL basic_busy_fall: got %b, required 00", {busy, done});
        else pass_cnt++;
        end_burst();
        chk_cnt++;
        if (written_cnt !== 4 || sb.size() !== 0)
            $display("FAIL basic_count: got %0d writes %0d pending, required 4 and 0", written_cnt, sb.size());
        else pass_cnt++;
        chk_cnt++;
        if (done_seen - d0 !== 1) $display("FAIL basic_done_count: got %0d, required 1", done_seen - d0);
        else pass_cnt++;
    endtask

    task automatic test_len0;
        int dc;
        int rq0;
        int we0;
        rq0 = rdreq_cycles; we0 = wren_cycles;
        start_burst(16'h1234, 16'h4321, 8'd0);
        wait_done("len0", 10, dc);
        chk_cnt++;
        if (dc - en_cyc !== 1) $display("FAIL len0_latency: got %0d, required 1", dc - en_cyc);
        else pass_cnt++;
        end_burst();
        chk_cnt++;
        if (rdreq_cycles !== rq0 || wren_cycles !== we0)
            $display("FAIL len0_activity: got %0d rd_req %0d wr_en cycles, required 0 and 0",
                     rdreq_cycles - rq0, wren_cycles - we0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int dc;
        int d0;
        bit hit;
        clear_counts();
        lat = 3; d0 = done_seen; hit = 0;
        start_burst(16'h0100, 16'h0300, 8'd16);
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #2;
            if (written_cnt >= 4) hit = 1;
        end
        chk_cnt++;
        if (!hit) $display("FAIL bp_reach4: got %0d writes, required 4", written_cnt);
        else pass_cnt++;
        wr_rdy_en = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk_cnt++;
        if (bus.rd_req !== 1'b0) $display("FAIL bp_stall: got rd_req %b, required 0", bus.rd_req);
        else pass_cnt++;
        wr_rdy_en = 1'b1;
        wait_done("bp", 200, dc);
        end_burst();
        chk_cnt++;
        if (written_cnt !== 16 || sb.size() !== 0)
            $display("FAIL bp_count: got %0d writes %0d pending, required 16 and 0", written_cnt, sb.size());
        else pass_cnt++;
        chk_cnt++;
        if (max_inflight !== FIFO_DEPTH)
            $display("FAIL bp_credit: got max inflight %0d, required %0d", max_inflight, FIFO_DEPTH);
        else pass_cnt++;
        chk_cnt++;
        if (done_seen - d0 !== 1) $display("FAIL bp_done_count: got %0d, required 1", done_seen - d0);
        else pass_cnt++;
        lat = 1;
    endtask

    task automatic test_wrap;
        int dc;
        logic [ADDR_W-1:0] exp_rd [3];
        exp_rd[0] = 16'hFFFE; exp_rd[1] = 16'hFFFF; exp_rd[2] = 16'h0000;
        clear_counts();
        rd_log.delete();
        start_burst(16'hFFFE, 16'hFFFF, 8'd3);
        wait_done("wrap", 50, dc);
        end_burst();
        chk_cnt++;
        if (rd_log.size() !== 3) $display("FAIL wrap_rd_count: got %0d, required 3", rd_log.size());
        else pass_cnt++;
        for (int k = 0; k < 3 && k < rd_log.size(); k++) begin
            chk_cnt++;
            if (rd_log[k] !== exp_rd[k]) $display("FAIL wrap_rd_addr%0d: got %h, required %h", k, rd_log[k], exp_rd[k]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (sb.size() !== 0) $display("FAIL wrap_pending: got %0d, required 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_hold_retrigger;
        int dc;
        int d0;
        d0 = done_seen;
        start_burst(16'h0500, 16'h0600, 8'd1);
        wait_done("hold", 50, dc);
        repeat (50) @(posedge clk);
        #2;
        chk_cnt++;
        if (done_seen - d0 !== 1 || busy !== 1'b0)
            $display("FAIL hold_single_done: got %0d dones busy %b, required 1 and 0", done_seen - d0, busy);
        else pass_cnt++;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        start_burst(16'h0700, 16'h0800, 8'd2);
        wait_done("retrig", 50, dc);
        end_burst();
        chk_cnt++;
        if (done_seen - d0 !== 2 || sb.size() !== 0)
            $display("FAIL retrig_done: got %0d dones %0d pending, required 2 and 0", done_seen - d0, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_spurious;
        int dc;
        int we0;
        we0 = wren_cycles;
        @(posedge clk); #2;
        inject = 1'b1;
        @(posedge clk); #2;
        chk_cnt++;
        if (err !== 1'b1) $display("FAIL spurious_err: got %b, required 1", err);
        else pass_cnt++;
        @(posedge clk); #2;
        chk_cnt++;
        if (wren_cycles !== we0 || err !== 1'b1)
            $display("FAIL spurious_nowrite: got %0d writes err %b, required 0 and 1", wren_cycles - we0, err);
        else pass_cnt++;
        start_burst(16'h0900, 16'h0A00, 8'd1);
        @(posedge clk); #2;
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL spurious_clear: got %b, required 0", err);
        else pass_cnt++;
        wait_done("spurious", 50, dc);
        end_burst();
    endtask

    task automatic test_reset_mid;
        int dc;
        bit hit;
        clear_counts();
        hit = 0;
        start_burst(16'h0040, 16'h0080, 8'd8);
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #2;
            if (written_cnt >= 5) hit = 1;
        end
        chk_cnt++;
        if (!hit || busy !== 1'b1) $display("FAIL rmid_reach5: got %0d writes busy %b, required 5 and 1", written_cnt, busy);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({done, busy, err, bus.rd_req, bus.wr_en} !== 5'b0)
            $display("FAIL rmid_ctrl: got %b, required 00000", {done, busy, err, bus.rd_req, bus.wr_en});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.rd_addr, bus.wr_addr, bus.wr_data} !== '0)
            $display("FAIL rmid_data: got %h %h %h, required 0", bus.rd_addr, bus.wr_addr, bus.wr_data);
        else pass_cnt++;
        sb.delete();
        enable = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        clear_counts();
        start_burst(16'h0C00, 16'h0D00, 8'd2);
        wait_done("rmid_recover", 50, dc);
        end_burst();
        chk_cnt++;
        if (written_cnt !== 2 || sb.size() !== 0 || err !== 1'b0)
            $display("FAIL rmid_recover: got %0d writes %0d pending err %b, required 2 0 0", written_cnt, sb.size(), err);
        else pass_cnt++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_backpressure();
        test_wrap();
        test_hold_retrigger();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
